// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_e;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam int unsigned MULDIV_WIDTH = 16;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide on {hi, lo}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             op,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_s;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] quo_s;

  always_comb begin
    sum    = '0;
    rem_s  = '0;
    trial  = '0;
    quo_s  = '0;
    hi_out = hi_in;
    lo_out = lo_in;
    if (op == OP_MUL) begin
      sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, operand} : '0);
      hi_out = sum[WIDTH:1];
      lo_out = {sum[0], lo_in[WIDTH-1:1]};
    end else begin
      // rem < divisor holds on entry, so a WIDTH+1-bit trial sign is exact.
      rem_s = {hi_in, lo_in[WIDTH-1]};
      quo_s = {lo_in[WIDTH-2:0], 1'b0};
      trial = rem_s - {1'b0, operand};
      if (!trial[WIDTH]) begin
        hi_out = trial[WIDTH-1:0];
        lo_out = quo_s | WIDTH'(1);
      end else begin
        hi_out = rem_s[WIDTH-1:0];
        lo_out = quo_s;
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative unsigned mul/div sequencer owning Hi/Lo; stalls the pipeline while busy.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             abort,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             freeze,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] wh_q, wh_d;
  logic [WIDTH-1:0] wl_q, wl_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] step_hi, step_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op      (state_q == DIV ? OP_DIV : OP_MUL),
    .hi_in   (wh_q),
    .lo_in   (wl_q),
    .operand (b_q),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    b_d     = b_q;
    wh_d    = wh_q;
    wl_d    = wl_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          b_d   = operand_b;
          wh_d  = '0;
          wl_d  = operand_a;
          cnt_d = '0;
          dbz_d = 1'b0;
          if (op == OP_DIV && operand_b == '0) begin
            hi_d    = operand_a;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = (op == OP_DIV) ? DIV : MUL;
          end
        end
      end
      MUL, DIV: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          wh_d  = step_hi;
          wl_d  = step_lo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            hi_d    = step_hi;
            lo_d    = step_lo;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      b_q     <= '0;
      wh_q    <= '0;
      wl_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      b_q     <= b_d;
      wh_q    <= wh_d;
      wl_q    <= wl_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dbz_q   <= dbz_d;
    end
  end

  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign busy        = (state_q == MUL) || (state_q == DIV);
  assign done        = (state_q == DONE);
  assign freeze      = busy || ((state_q == IDLE) && start && !abort);

endmodule
